// File: rtl/ttl_scan_decoder.sv
// Scanning multi-block decoder: one registered select address shared by BLOCKS
// active-low one-hot decoders, loadable from A or auto-incremented with wrap.
module ttl_scan_decoder #(
    parameter int BLOCKS     = 2,
    parameter int WIDTH_OUT  = 4,
    parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                        Clk,
    input  logic                        Clear,
    input  logic                        Load,
    input  logic                        Scan,
    input  logic [WIDTH_IN-1:0]         A,
    input  logic [BLOCKS-1:0]           Enable_bar,
    output logic [BLOCKS*WIDTH_OUT-1:0] Y_2D,
    output logic [WIDTH_IN-1:0]         Index,
    output logic                        Carry,
    output logic                        Load_error
);

    localparam logic [WIDTH_IN-1:0] LAST  = WIDTH_IN'(WIDTH_OUT - 1);
    localparam logic [WIDTH_IN:0]   COUNT = (WIDTH_IN + 1)'(WIDTH_OUT);

    logic [WIDTH_IN-1:0]         addr;
    logic                        load_error_q;
    logic                        a_in_range;
    logic                        at_last;
    logic                        carry_c;
    logic [WIDTH_OUT-1:0]        y_blk [BLOCKS];
    logic [BLOCKS*WIDTH_OUT-1:0] y_pack;

    // The extra MSB lets the range test see A >= WIDTH_OUT even when WIDTH_OUT is 2**WIDTH_IN.
    assign a_in_range = {1'b0, A} < COUNT;
    assign at_last    = (addr == LAST);
    assign carry_c    = Scan & ~Load & at_last;

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            addr         <= '0;
            load_error_q <= 1'b0;
        end else if (Load) begin
            if (a_in_range) begin
                addr         <= A;
                load_error_q <= 1'b0;
            end else begin
                load_error_q <= 1'b1;
            end
        end else begin
            load_error_q <= 1'b0;
            if (Scan) begin
                addr <= at_last ? '0 : addr + 1'b1;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < BLOCKS; b++) begin
            for (int i = 0; i < WIDTH_OUT; i++) begin
                y_blk[b][i] = !(!Enable_bar[b] && (addr == WIDTH_IN'(i)));
            end
        end
    end

    // PACK_ARRAY: block b lands on bits [b*WIDTH_OUT +: WIDTH_OUT].
    always_comb begin
        y_pack = '1;
        for (int b = 0; b < BLOCKS; b++) begin
            y_pack[b*WIDTH_OUT +: WIDTH_OUT] = y_blk[b];
        end
    end

    generate
        if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodelay
            assign Y_2D       = y_pack;
            assign Index      = addr;
            assign Carry      = carry_c;
            assign Load_error = load_error_q;
        end else begin : g_delay
            assign #(DELAY_RISE, DELAY_FALL) Y_2D       = y_pack;
            assign #(DELAY_RISE, DELAY_FALL) Index      = addr;
            assign #(DELAY_RISE, DELAY_FALL) Carry      = carry_c;
            assign #(DELAY_RISE, DELAY_FALL) Load_error = load_error_q;
        end
    endgenerate

endmodule

// File: tb/tb_ttl_scan_decoder.sv
// Bench for ttl_scan_decoder: three configurations (2x4, 2x6, 3x8) driven together,
// expectations from an arithmetic address model, checked by a queue-draining monitor.
module tb_ttl_scan_decoder;

    localparam int SB_W = 48;
    localparam int WO_T [3]  = '{4, 6, 8};
    localparam int BLK_T [3] = '{2, 2, 3};
    localparam int WIN_T [3] = '{2, 3, 3};

    logic Clk;
    logic Clear;
    logic       ld [3];
    logic       sc [3];
    logic [3:0] a_st [3];
    logic [2:0] en_st [3];

    logic [7:0]  y0;
    logic [11:0] y1;
    logic [23:0] y2;
    logic [1:0]  idx0;
    logic [2:0]  idx1, idx2;
    logic        c0, c1, c2;
    logic        le0, le1, le2;

    int m_addr [3];
    bit m_err [3];

    logic [SB_W-1:0] exp_q [$];
    string           tag_q [$];
    event            sample_ev;
    int              n_checks = 0;
    int              n_errors = 0;

    ttl_scan_decoder #(.BLOCKS(2), .WIDTH_OUT(4)) u_dut0 (
        .Clk(Clk), .Clear(Clear), .Load(ld[0]), .Scan(sc[0]), .A(a_st[0][1:0]),
        .Enable_bar(en_st[0][1:0]), .Y_2D(y0), .Index(idx0), .Carry(c0), .Load_error(le0)
    );
    ttl_scan_decoder #(.BLOCKS(2), .WIDTH_OUT(6)) u_dut1 (
        .Clk(Clk), .Clear(Clear), .Load(ld[1]), .Scan(sc[1]), .A(a_st[1][2:0]),
        .Enable_bar(en_st[1][1:0]), .Y_2D(y1), .Index(idx1), .Carry(c1), .Load_error(le1)
    );
    ttl_scan_decoder #(.BLOCKS(3), .WIDTH_OUT(8)) u_dut2 (
        .Clk(Clk), .Clear(Clear), .Load(ld[2]), .Scan(sc[2]), .A(a_st[2][2:0]),
        .Enable_bar(en_st[2]), .Y_2D(y2), .Index(idx2), .Carry(c2), .Load_error(le2)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, string what, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", tag, what, act, exp, $time);
        end
    endtask

    // reference model: outputs as a function of the address integer
    function automatic logic [31:0] model_y(int d, int addr, logic [2:0] en);
        logic [31:0] y;
        logic [31:0] full;
        logic [31:0] blk;
        y = '0;
        full = (32'd1 << WO_T[d]) - 32'd1;
        for (int b = 0; b < BLK_T[d]; b++) begin
            blk = en[b] ? full : (full & ~(32'd1 << addr));
            y = y | (blk << (b * WO_T[d]));
        end
        return y;
    endfunction

    task automatic model_edge();
        if (Clear) return;
        for (int d = 0; d < 3; d++) begin
            if (ld[d]) begin
                if (int'(a_st[d]) < WO_T[d]) begin
                    m_addr[d] = int'(a_st[d]);
                    m_err[d]  = 1'b0;
                end else begin
                    m_err[d] = 1'b1;
                end
            end else begin
                m_err[d] = 1'b0;
                if (sc[d]) m_addr[d] = (m_addr[d] + 1) % WO_T[d];
            end
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            m_addr[d] = 0;
            m_err[d]  = 1'b0;
        end
    endtask

    task automatic push_all(string tag);
        logic [SB_W-1:0] e;
        for (int d = 0; d < 3; d++) begin
            e = '0;
            e[45:44] = 2'(d);
            e[43]    = m_err[d];
            e[42]    = sc[d] & ~ld[d] & (m_addr[d] == WO_T[d] - 1);
            e[39:32] = 8'(m_addr[d]);
            e[31:0]  = model_y(d, m_addr[d], en_st[d]);
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    // driver tasks: called between edges with staged inputs final
    task automatic cycle(string tag);
        model_edge();
        push_all(tag);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic comb_check(string tag);
        push_all(tag);
        -> sample_ev;
        #2;
    endtask

    // monitor / scoreboard
    initial begin
        logic [SB_W-1:0] e;
        string t;
        logic [31:0] y_a;
        logic [7:0]  i_a;
        logic        c_a, e_a;
        forever begin
            @(posedge Clk or sample_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                case (e[45:44])
                    2'd0:    begin y_a = 32'(y0); i_a = 8'(idx0); c_a = c0; e_a = le0; end
                    2'd1:    begin y_a = 32'(y1); i_a = 8'(idx1); c_a = c1; e_a = le1; end
                    default: begin y_a = 32'(y2); i_a = 8'(idx2); c_a = c2; e_a = le2; end
                endcase
                check(t, $sformatf("dut%0d Y_2D", e[45:44]), y_a, e[31:0]);
                check(t, $sformatf("dut%0d Index", e[45:44]), 32'(i_a), 32'(e[39:32]));
                check(t, $sformatf("dut%0d Carry", e[45:44]), 32'(c_a), 32'(e[42]));
                check(t, $sformatf("dut%0d Load_error", e[45:44]), 32'(e_a), 32'(e[43]));
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            ld[d] = 1'b0; sc[d] = 1'b0; a_st[d] = '0; en_st[d] = '0;
        end
        Clear = 1'b1;
        model_clear();

        // reset state before any clock edge
        #1;
        comb_check("reset");
        check("reset", "dut0 Y_2D literal", 32'(y0), 32'h0000_00EE);
        @(negedge Clk);
        Clear = 1'b0;

        // free scan through the wrap
        sc[0] = 1'b1;
        for (int k = 0; k < 5; k++) cycle("scan5");

        // load beats scan, then enable change shows without an edge
        ld[0] = 1'b1; a_st[0] = 4'd2;
        cycle("load_wins");
        ld[0] = 1'b0; sc[0] = 1'b0; en_st[0] = 3'b010;
        comb_check("enable_comb");
        check("enable_comb", "dut0 Y_2D literal", 32'(y0), 32'h0000_00FB);

        // out-of-range loads on the 6-output decoder
        ld[1] = 1'b1; a_st[1] = 4'd3;
        cycle("w6_load3");
        a_st[1] = 4'd7;
        cycle("w6_bad7");
        a_st[1] = 4'd6;
        cycle("w6_bad6");
        ld[1] = 1'b0;
        cycle("w6_err_clr");
        ld[1] = 1'b1; a_st[1] = 4'd5;
        cycle("w6_load5");
        ld[1] = 1'b0; sc[1] = 1'b1;
        comb_check("w6_carry");
        cycle("w6_wrap");
        sc[1] = 1'b0;

        // asynchronous clear mid-scan
        ld[0] = 1'b1; a_st[0] = 4'd0; en_st[0] = 3'b000;
        cycle("pre_clr_load");
        ld[0] = 1'b0; sc[0] = 1'b1;
        cycle("pre_clr_scan");
        cycle("pre_clr_scan");
        #1;
        Clear = 1'b1;
        model_clear();
        comb_check("clr_async");
        @(negedge Clk);
        cycle("clr_held");
        cycle("clr_held");
        Clear = 1'b0;
        cycle("clr_release");
        sc[0] = 1'b0;

        // three blocks, middle one enabled
        en_st[2] = 3'b101; ld[2] = 1'b1; a_st[2] = 4'd6;
        cycle("w8_load6");
        ld[2] = 1'b0;
        check("w8_load6", "dut2 Y_2D literal", 32'(y2), 32'h00FF_BFFF);

        // randomized traffic with occasional asynchronous clears
        for (int it = 0; it < 400; it++) begin
            for (int d = 0; d < 3; d++) begin
                ld[d]    = ($urandom_range(0, 3) == 0);
                sc[d]    = 1'($urandom_range(0, 1));
                a_st[d]  = 4'($urandom_range(0, (1 << WIN_T[d]) - 1));
                en_st[d] = 3'($urandom_range(0, (1 << BLK_T[d]) - 1));
            end
            if ($urandom_range(0, 19) == 0) begin
                Clear = 1'b1;
                model_clear();
                comb_check("rand_clr");
                Clear = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                comb_check("rand_comb");
            end
            cycle("rand");
        end

        @(negedge Clk);
        check("drain", "queue entries left", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
